// File: rtl/ni_injector_if.sv
// ni_injector_if: host descriptor/payload handshake and router LOCAL-port flit link of the NI injector.
interface ni_injector_if #(parameter int TAM_FLIT = 16);
    logic                i_req_valid;
    logic [TAM_FLIT-1:0] i_target;
    logic [TAM_FLIT-1:0] i_size;
    logic                o_req_ready;
    logic                i_pl_valid;
    logic [TAM_FLIT-1:0] i_pl_data;
    logic                o_pl_ready;
    logic                o_tx;
    logic [TAM_FLIT-1:0] o_data;
    logic                i_credit;
    logic                o_clk_tx;
    logic                o_busy;
    logic                o_pkt_done;
    logic                o_err;
    modport slave (
        input  i_req_valid, i_target, i_size, i_pl_valid, i_pl_data, i_credit,
        output o_req_ready, o_pl_ready, o_tx, o_data, o_clk_tx, o_busy, o_pkt_done, o_err
    );
    modport master (
        output i_req_valid, i_target, i_size, i_pl_valid, i_pl_data, i_credit,
        input  o_req_ready, o_pl_ready, o_tx, o_data, o_clk_tx, o_busy, o_pkt_done, o_err
    );
endinterface

// File: rtl/ni_injector.sv
// ni_injector: turns a host descriptor plus payload stream into a header/size/payload flit packet.
// Defining NI_INJECTOR_PKT_CNT_EN adds the 16-bit o_pkt_count completed-packet counter.
module ni_injector #(
    parameter int TAM_FLIT = 16,
    parameter int MAX_SIZE = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    ni_injector_if.slave bus
`ifdef NI_INJECTOR_PKT_CNT_EN
    ,
    output logic [15:0] o_pkt_count
`endif
);
    localparam logic [TAM_FLIT-1:0] MAX_LEN = TAM_FLIT'(MAX_SIZE);
    typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, DONE} state_t;
    state_t              state;
    logic [TAM_FLIT-1:0] target_q, size_q, cnt;
    logic                err, busy, done, rdy, xfer;
    assign xfer            = bus.o_tx & bus.i_credit;
    assign bus.o_tx        = state == HEADER || state == SIZE || (state == PAYLOAD && bus.i_pl_valid);
    assign bus.o_data      = state == HEADER ? target_q : state == SIZE ? size_q :
                             state == PAYLOAD ? bus.i_pl_data : '0;
    assign bus.o_pl_ready  = state == PAYLOAD && bus.i_credit;
    assign bus.o_clk_tx    = i_clk;
    assign bus.o_err       = err;
    assign bus.o_busy      = busy;
    assign bus.o_pkt_done  = done;
    assign bus.o_req_ready = rdy;
    // busy/done/ready are registered alongside the state so they change only with it
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            target_q <= '0;
            size_q   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdy      <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.i_req_valid) begin
                    target_q <= bus.i_target;
                    size_q   <= bus.i_size;
                    if (bus.i_size <= MAX_LEN) begin
                        state <= HEADER;
                        busy  <= 1'b1;
                        rdy   <= 1'b0;
                    end else err <= 1'b1;
                end
                HEADER: if (xfer) state <= SIZE;
                SIZE: if (xfer) begin
                    cnt   <= size_q;
                    state <= size_q == '0 ? DONE : PAYLOAD;
                    done  <= size_q == '0;
                end
                PAYLOAD: if (xfer) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == TAM_FLIT'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end
`ifdef NI_INJECTOR_PKT_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_pkt_count <= '0;
        else if (state == DONE) o_pkt_count <= o_pkt_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ni_injector.sv
// tb_ni_injector: randomized scoreboard bench; expected flit streams are built from packet descriptors.
module tb_ni_injector;
    localparam int W = 16;
    localparam int MAXS = 255;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ni_injector_if #(.TAM_FLIT(W)) bus();
`ifdef NI_INJECTOR_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif
    ni_injector #(.TAM_FLIT(W), .MAX_SIZE(MAXS)) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus(bus)
`ifdef NI_INJECTOR_PKT_CNT_EN
        ,
        .o_pkt_count(pkt_count)
`endif
    );
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int exp_done = 0, obs_done = 0, flits = 0, model_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every transfer pops the scoreboard; stalled flits must hold their data
    initial begin
        logic prev_stall, prev_done;
        logic [W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_done = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_stall && bus.o_tx) check("hold_data", 32'(bus.o_data), 32'(prev_data));
                if (bus.o_tx && bus.i_credit) begin
                    flits++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_flit: got %0h expected none at %0t", bus.o_data, $time);
                    end else check("flit", 32'(bus.o_data), 32'(exp_q.pop_front()));
                end
                if (bus.o_pkt_done) begin
                    obs_done++;
                    check("done_after_last_flit", 32'(exp_q.size()), 0);
                    check("done_single_cycle", 32'(prev_done), 0);
                end
                prev_stall = bus.o_tx && !bus.i_credit;
                prev_data = bus.o_data;
                prev_done = bus.o_pkt_done;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(bus.o_tx), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_err", 32'(bus.o_err), 0);
        check("rst_done", 32'(bus.o_pkt_done), 0);
        exp_q.delete();
        model_cnt = 0;
        bus.i_req_valid = 1'b0;
        bus.i_pl_valid = 1'b0;
        bus.i_credit = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("req_ready_after_rst", 32'(bus.o_req_ready), 1);
`ifdef NI_INJECTOR_PKT_CNT_EN
        check("pkt_count_rst", 32'(pkt_count), 0);
`endif
        @(posedge clk);
        #1;
    endtask

    // cw/cn: credit held low cn cycles at flit index cw; bw/bn: bubble bn cycles at flit index bw
    task automatic send(input logic [W-1:0] tgt, input logic [W-1:0] sz, input bit rnd,
                        input int cw, input int cn, input int bw, input int bn,
                        input int abort_at, output int cycles);
        logic [W-1:0] pl[$];
        int n, idx, cs, bs, guard;
        bit ok, c;
        ok = int'(sz) <= MAXS;
        idx = 0;
        cs = cn;
        bs = bn;
        cycles = 0;
        for (int i = 0; ok && i < int'(sz); i++) pl.push_back(W'($urandom));
        bus.i_req_valid = 1'b1;
        bus.i_target = tgt;
        bus.i_size = sz;
        guard = 0;
        @(negedge clk);
        while (!bus.o_req_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard == 50) check("req_timeout", 0, 1);
        if (ok) begin
            exp_q.push_back(tgt);
            exp_q.push_back(sz);
            foreach (pl[i]) exp_q.push_back(pl[i]);
        end
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        if (!ok) return;
        n = int'(sz) + 2;
        while (idx < n && cycles < 1000) begin
            c = rnd ? ($urandom_range(0, 3) != 0) : !(idx == cw && cs > 0);
            if (!rnd && idx == cw && cs > 0) cs--;
            bus.i_credit = c;
            c = rnd ? ($urandom_range(0, 3) != 0) : !(idx == bw && bs > 0);
            if (!rnd && idx == bw && bs > 0) bs--;
            bus.i_pl_valid = idx >= 2 && c;
            bus.i_pl_data = idx >= 2 ? pl[idx-2] : W'($urandom);
            @(negedge clk);
            cycles++;
            check("busy", 32'(bus.o_busy), 1);
            check("req_ready_low", 32'(bus.o_req_ready), 0);
            check("pl_ready", 32'(bus.o_pl_ready), idx >= 2 ? 32'(bus.i_credit) : 0);
            if (bus.o_tx && bus.i_credit) idx++;
            if (idx == abort_at) begin
                do_reset();
                check("no_flits_after_abort", 32'(bus.o_tx), 0);
                return;
            end
            @(posedge clk);
            #1;
        end
        if (idx < n) check("flit_timeout", 32'(idx), 32'(n));
        bus.i_pl_valid = 1'b0;
        bus.i_credit = 1'b1;
        exp_done++;
        model_cnt++;
        guard = 0;
        while (obs_done < exp_done && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        check("pkt_done_seen", 32'(obs_done), 32'(exp_done));
    endtask

    initial begin
        int cyc, f0;
        bus.i_req_valid = 1'b0;
        bus.i_target = '0;
        bus.i_size = '0;
        bus.i_pl_valid = 1'b0;
        bus.i_pl_data = '0;
        bus.i_credit = 1'b1;
        #12;
        check("init_tx", 32'(bus.o_tx), 0);
        check("init_busy", 32'(bus.o_busy), 0);
        check("init_err", 32'(bus.o_err), 0);
        check("init_done", 32'(bus.o_pkt_done), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("req_ready_first", 32'(bus.o_req_ready), 1);
        check("clk_tx_low", 32'(bus.o_clk_tx), 0);
        @(posedge clk);
        #1 check("clk_tx_high", 32'(bus.o_clk_tx), 1);
        // basic 3-word packet, full credit: five consecutive flits
        send(16'h0011, 16'd3, 1'b0, -1, 0, -1, 0, -1, cyc);
        check("s1_cycles", 32'(cyc), 5);
        // zero-length packet: header and size only
        f0 = flits;
        send(16'h0022, 16'd0, 1'b0, -1, 0, -1, 0, -1, cyc);
        check("s2_cycles", 32'(cyc), 2);
        check("s2_flits", 32'(flits - f0), 2);
        // credit stall on 2nd payload word, bubble on 4th
        f0 = flits;
        send(16'h0033, 16'd4, 1'b0, 3, 3, 5, 2, -1, cyc);
        check("s3_cycles", 32'(cyc), 11);
        check("s3_flits", 32'(flits - f0), 6);
        // oversize descriptor rejected, sticky error
        send(16'h0044, W'(MAXS + 1), 1'b0, -1, 0, -1, 0, -1, cyc);
        for (int i = 0; i < 3; i++) begin
            check("s4_err", 32'(bus.o_err), 1);
            check("s4_req_ready", 32'(bus.o_req_ready), 1);
            check("s4_no_tx", 32'(bus.o_tx), 0);
            @(posedge clk);
            #1;
        end
        send(16'h0055, 16'd2, 1'b0, -1, 0, -1, 0, -1, cyc);
        check("s4_err_sticky", 32'(bus.o_err), 1);
        // reset after the header of a 5-word packet
        send(16'h0066, 16'd5, 1'b0, -1, 0, -1, 0, 1, cyc);
        send(16'h0077, 16'd1, 1'b0, -1, 0, -1, 0, -1, cyc);
        check("s5_cycles", 32'(cyc), 3);
        // three back-to-back packets from a fresh reset
        do_reset();
        for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom_range(0, 3)), 1'b0, -1, 0, -1, 0, -1, cyc);
`ifdef NI_INJECTOR_PKT_CNT_EN
        @(posedge clk);
        #1 check("pkt_count_3", 32'(pkt_count), 3);
`endif
        // randomized packets with random stalls and occasional oversize requests
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? W'(MAXS + 1 + $urandom_range(0, 100)) : W'($urandom_range(0, 10));
            send(W'($urandom), sz, 1'b1, -1, 0, -1, 0, -1, cyc);
            if (int'(sz) > MAXS) check("rand_err", 32'(bus.o_err), 1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        check("done_total", 32'(obs_done), 32'(exp_done));
`ifdef NI_INJECTOR_PKT_CNT_EN
        check("pkt_count_final", 32'(pkt_count), 32'(model_cnt));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ni_injector.md
NI_INJECTOR -- requirements
Module: ni_injector

Interface
REQ-001 The block SHALL have parameter TAM_FLIT, default 16, giving the flit width in bits (minimum 8).
REQ-002 The block SHALL have parameter MAX_SIZE, default 255, giving the largest accepted payload length in flits.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clk  in  1  single clock for all sequential logic.
- i_rst  in  1  asynchronous active-low reset.
- i_req_valid  in  1  host offers a packet descriptor.
- i_target  in  TAM_FLIT  destination router address; becomes the header flit.
- i_size  in  TAM_FLIT  payload length in flits.
- o_req_ready  out  1  descriptor accepted this cycle.
- i_pl_valid  in  1  host payload word valid.
- i_pl_data  in  TAM_FLIT  payload word.
- o_pl_ready  out  1  payload word consumed this cycle.
- o_tx  out  1  flit valid toward the router LOCAL-port buffer.
- o_data  out  TAM_FLIT  flit toward the router.
- i_credit  in  1  router LOCAL buffer can accept a flit.
- o_clk_tx  out  1  forwarded i_clk.
- o_busy  out  1  packet in progress.
- o_pkt_done  out  1  one-cycle pulse after the last flit of a packet transfers.
- o_err  out  1  sticky flag: descriptor rejected for size > MAX_SIZE.

Function
REQ-004 A flit SHALL transfer on a rising i_clk edge where o_tx=1 and i_credit=1; no other edge transfers a flit.
REQ-005 The FSM SHALL have the states IDLE, HEADER, SIZE, PAYLOAD and DONE.
REQ-006 In IDLE, o_req_ready SHALL be 1. A cycle with i_req_valid=1 SHALL latch i_target and i_size into internal registers.
REQ-007 On that latch, if i_size <= MAX_SIZE the FSM SHALL go to HEADER. Otherwise it SHALL stay in IDLE and set o_err.
REQ-008 In HEADER, o_tx SHALL be 1 and o_data SHALL be the latched target. On transfer the FSM SHALL go to SIZE.
REQ-009 In SIZE, o_tx SHALL be 1 and o_data SHALL be the latched size. On transfer it SHALL go to PAYLOAD if size > 0, else to DONE.
REQ-010 In PAYLOAD:
- o_tx SHALL equal i_pl_valid, o_data SHALL equal i_pl_data, and o_pl_ready SHALL equal i_credit.
- A down-counter loaded with size SHALL decrement on each transfer.
- On the transfer that brings the counter to 0 the FSM SHALL go to DONE.
REQ-011 In DONE, o_pkt_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. A new descriptor is accepted no earlier than the following cycle.
REQ-012 Outside PAYLOAD, o_pl_ready SHALL be 0. Outside HEADER, SIZE and PAYLOAD, o_tx SHALL be 0.
REQ-013 o_busy SHALL be 1 in HEADER, SIZE, PAYLOAD and DONE.
REQ-014 o_req_ready SHALL be 0 in every state except IDLE.
REQ-015 i_credit low SHALL stall the current flit indefinitely, with o_data held stable.
REQ-016 A payload bubble (i_pl_valid=0) SHALL stall without counter change.
REQ-017 o_clk_tx SHALL be i_clk passed through combinationally.
REQ-018 o_err SHALL be cleared only by reset.

Reset
REQ-019 i_rst=0 SHALL immediately force all of the following, regardless of i_clk:
- FSM to IDLE.
- counter, latched target and latched size to 0.
- o_err=0, o_pkt_done=0, o_tx=0, o_busy=0.
REQ-020 Reset asserted mid-packet SHALL abandon the packet, with no further flits after release.
REQ-021 After reset release, o_req_ready SHALL be 1 on the first cycle.

Configuration
REQ-022 Macro NI_INJECTOR_PKT_CNT_EN SHALL control an extra output, o_pkt_count (out, 16 bits).
- Defined: o_pkt_count SHALL increment by 1 on every DONE cycle, wrap from 65535 to 0, and reset to 0.
- Undefined: the port and counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Target 0x0011, size 3, payload A,B,C, i_credit=1 -> o_data 0x0011,0x0003,A,B,C on 5 consecutive cycles; o_pkt_done pulses once.
- Size 0, target 0x0022 -> exactly two flits 0x0022,0x0000, then the DONE pulse.
- Size 4 with i_credit low 3 cycles during the second payload word and i_pl_valid low 2 cycles on the fourth -> o_data held; exactly 6 flits transfer.
- Size MAX_SIZE+1 -> no o_tx, o_err=1, o_req_ready stays 1; a following size-2 request sends normally and o_err stays 1.
- Reset pulsed after the header of a size-5 packet -> o_tx 0, o_busy 0 immediately; the next request starts with its own header.
- With NI_INJECTOR_PKT_CNT_EN defined, 3 back-to-back packets -> o_pkt_count=3.
